// File: rtl/bnn_layer_sched_if.sv
// Bundles the layer sequencer's control, data and weight/threshold RAM signals.
// Latency: n/a (wires only); the master drives Start/InVec/RAM data, the slave the rest.
// Backpressure: none; Start is a single-cycle request that is accepted only when idle.
// Optional macro BNN_SCHED_ABORT_EN adds the Abort request line.
interface bnn_layer_sched_if #(
   parameter int IN_CHUNKS = 4,
   parameter int NEURONS   = 8,
   parameter int ACC_W     = $clog2(4*IN_CHUNKS+1),
   parameter int WA_W      = $clog2(NEURONS*IN_CHUNKS),
   parameter int TA_W      = $clog2(NEURONS)
);
   logic                   Start;
   logic [4*IN_CHUNKS-1:0] InVec;
   logic [WA_W-1:0]        WAddr;
   logic                   WRdEn;
   logic [3:0]             WData;
   logic [TA_W-1:0]        TAddr;
   logic                   TRdEn;
   logic [ACC_W-1:0]       TData;
   logic                   Busy;
   logic                   Done;
   logic [NEURONS-1:0]     OutVec;
`ifdef BNN_SCHED_ABORT_EN
   logic                   Abort;
`endif

   modport master (
      output Start, InVec, WData, TData,
`ifdef BNN_SCHED_ABORT_EN
      output Abort,
`endif
      input  WAddr, WRdEn, TAddr, TRdEn, Busy, Done, OutVec
   );

   modport slave (
      input  Start, InVec, WData, TData,
`ifdef BNN_SCHED_ABORT_EN
      input  Abort,
`endif
      output WAddr, WRdEn, TAddr, TRdEn, Busy, Done, OutVec
   );
endinterface

// File: rtl/bnn_layer_sched.sv
// Time-multiplexes one 4-input XNOR-popcount slice across a binary layer and thresholds each neuron.
// Latency: Done is high NEURONS*(IN_CHUNKS+1)+1 cycles after Start acceptance (41 with defaults).
// Backpressure: none; Start is ignored while Busy. BNN_SCHED_ABORT_EN adds Abort, which cancels a run.
module bnn_layer_sched #(
   parameter int IN_CHUNKS = 4,
   parameter int NEURONS   = 8,
   parameter int ACC_W     = $clog2(4*IN_CHUNKS+1),
   parameter int WA_W      = $clog2(NEURONS*IN_CHUNKS),
   parameter int TA_W      = $clog2(NEURONS)
) (
   input logic               Clk,
   input logic               Reset,
   bnn_layer_sched_if.slave  bus
);

   localparam int IN_W = 4*IN_CHUNKS;
   localparam int K_W  = $clog2(IN_CHUNKS+1);
   // Chunk index of the compare cycle and of the cycle that also fetches the threshold.
   localparam logic [K_W-1:0]  K_LAST = K_W'(IN_CHUNKS);
   localparam logic [K_W-1:0]  K_TRD  = K_W'(IN_CHUNKS-1);
   localparam logic [TA_W-1:0] N_LAST = TA_W'(NEURONS-1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t             state_q, state_d;
   logic [TA_W-1:0]    n_q, n_d;
   logic [K_W-1:0]     k_q, k_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [IN_W-1:0]    in_q, in_d;
   logic [NEURONS-1:0] out_q, out_d;

   logic [3:0]         chunk;
   logic [3:0]         match;
   logic [2:0]         pc;
   logic [ACC_W-1:0]   acc_sum;

   // State register; async reset aborts any run and returns everything to zero.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         n_q     <= '0;
         k_q     <= '0;
         acc_q   <= '0;
         in_q    <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         in_q    <= in_d;
         out_q   <= out_d;
      end
   end

   // Popcount of input/weight agreement for the chunk whose weight arrives this cycle (k-1).
   always_comb begin
      chunk = '0;
      for (int j = 0; j < IN_CHUNKS; j++) begin
         if (k_q == K_W'(j+1)) chunk = in_q[4*j +: 4];
      end
      match   = ~(chunk ^ bus.WData);
      pc      = 3'(match[0]) + 3'(match[1]) + 3'(match[2]) + 3'(match[3]);
      acc_sum = acc_q + ACC_W'(pc);
   end

   // Next-state: walk chunks of each neuron, compare on the extra cycle, then step neuron.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      k_d     = k_q;
      acc_d   = acc_q;
      in_d    = in_q;
      out_d   = out_q;
      case (state_q)
         IDLE: begin
            if (bus.Start) begin
               state_d = RUN;
               in_d    = bus.InVec;
               out_d   = '0;
               n_d     = '0;
               k_d     = '0;
               acc_d   = '0;
            end
         end
         RUN: begin
            if (k_q != '0) acc_d = acc_sum;
            if (k_q == K_LAST) begin
               // Threshold read was issued with the last weight, so TData is valid now.
               out_d[n_q] = (acc_sum >= bus.TData);
               acc_d      = '0;
               k_d        = '0;
               if (n_q == N_LAST) state_d = FIN;
               else               n_d     = n_q + 1'b1;
            end else begin
               k_d = k_q + 1'b1;
            end
`ifdef BNN_SCHED_ABORT_EN
            // Abort wins over this cycle's work; finished bits are kept, the rest stay 0.
            if (bus.Abort) begin
               state_d = IDLE;
               out_d   = out_q;
               acc_d   = '0;
               k_d     = '0;
               n_d     = '0;
            end
`endif
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // RAM requests and status decode straight from state, so reset clears them immediately.
   always_comb begin
      bus.WRdEn  = (state_q == RUN) && (k_q != K_LAST);
      bus.WAddr  = bus.WRdEn ? (WA_W'(n_q) * WA_W'(IN_CHUNKS) + WA_W'(k_q)) : '0;
      bus.TRdEn  = (state_q == RUN) && (k_q == K_TRD);
      bus.TAddr  = bus.TRdEn ? n_q : '0;
      bus.Busy   = (state_q != IDLE);
      bus.Done   = (state_q == FIN);
      bus.OutVec = out_q;
   end

endmodule

// File: tb/tb_bnn_layer_sched.sv
// Directed bench for bnn_layer_sched: a RAM model, a stimulus thread that queues expected
// results, and a monitor that checks OutVec, Done latency and the RAM address walk.
module tb_bnn_layer_sched;

   localparam int LAT = 41;

   logic Clk;
   logic Reset;

   bnn_layer_sched_if bus ();

   bnn_layer_sched dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic [3:0] wmem [32];
   logic [4:0] tmem [8];

   // One-cycle synchronous read RAMs.
   always @(posedge Clk) begin
      if (bus.WRdEn) bus.WData <= wmem[bus.WAddr];
      if (bus.TRdEn) bus.TData <= tmem[bus.TAddr];
   end

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Monitor: address walk while busy, and result/latency on every Done pulse.
   initial begin
      bit in_run = 0;
      bit prev_done = 0;
      int run_cyc = 0;
      int rd_idx = 0;
      forever begin
         @(negedge Clk);
         if (Reset) begin
            in_run = 0;
            prev_done = 0;
         end else begin
            if (prev_done) check("busy_after_done", {31'd0, bus.Busy}, 32'd0);
            prev_done = bus.Done;
            if (bus.Busy && !in_run) begin
               in_run = 1;
               run_cyc = 1;
               rd_idx = 0;
            end else if (in_run) begin
               run_cyc++;
            end
            if (in_run && !bus.Busy) in_run = 0;
            if (in_run && bus.WRdEn) begin
               check("waddr", {27'd0, bus.WAddr}, rd_idx);
               rd_idx++;
            end
            if (in_run && bus.TRdEn) begin
               check("taddr", {29'd0, bus.TAddr}, (rd_idx - 1) / 4);
               check("trd_slot", (rd_idx - 1) % 4, 3);
            end
            if (bus.Done) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_done", 1, 0);
               end else begin
                  check("outvec", {24'd0, bus.OutVec}, {24'd0, exp_q.pop_front()});
                  check("done_latency", run_cyc, LAT);
                  check("read_count", rd_idx, 32);
               end
            end
         end
      end
   end

   task automatic load_uniform(input logic [3:0] w, input logic [4:0] t);
      for (int i = 0; i < 32; i++) wmem[i] = w;
      for (int i = 0; i < 8; i++) tmem[i] = t;
   endtask

   // Weights that make neuron n agree on exactly 2n bits of the given input, filling chunks in order.
   task automatic load_graded(input logic [15:0] iv);
      for (int n = 0; n < 8; n++) begin
         for (int c = 0; c < 4; c++) begin
            int p;
            logic [3:0] x;
            logic [3:0] m;
            p = 2*n - 4*c;
            if (p < 0) p = 0;
            if (p > 4) p = 4;
            x = iv[4*c +: 4];
            m = 4'((1 << p) - 1);
            wmem[n*4 + c] = ~x ^ m;
         end
      end
   endtask

   // Issues Start and leaves the bench at the negedge of run cycle 1.
   task automatic pulse_start(input logic [15:0] iv);
      @(negedge Clk);
      bus.Start = 1'b1;
      bus.InVec = iv;
      @(negedge Clk);
      bus.Start = 1'b0;
      bus.InVec = ~iv;
   endtask

   task automatic wait_done();
      bit seen = 0;
      for (int i = 0; i < 80; i++) begin
         if (bus.Done) begin
            seen = 1;
            break;
         end
         @(negedge Clk);
      end
      check("done_seen", {31'd0, seen}, 32'd1);
      repeat (2) @(negedge Clk);
   endtask

   task automatic run(input logic [15:0] iv, input logic [7:0] exp, input int restart_at);
      exp_q.push_back(exp);
      pulse_start(iv);
      if (restart_at > 1) begin
         repeat (restart_at - 1) @(negedge Clk);
         bus.Start = 1'b1;
         bus.InVec = 16'h0000;
         @(negedge Clk);
         bus.Start = 1'b0;
      end
      wait_done();
   endtask

   initial begin
      Reset = 1'b0;
      bus.Start = 1'b0;
      bus.InVec = '0;
`ifdef BNN_SCHED_ABORT_EN
      bus.Abort = 1'b0;
`endif
      #1 Reset = 1'b1;
      #2;
      check("reset_outs", {bus.WAddr, bus.WRdEn, bus.TAddr, bus.TRdEn, bus.Busy, bus.Done, bus.OutVec},
            32'd0);
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;

      // All agree, threshold equals the maximum count.
      load_uniform(4'hF, 5'd16);
      run(16'hFFFF, 8'hFF, 0);
      // No agreement anywhere.
      load_uniform(4'hF, 5'd1);
      run(16'h0000, 8'h00, 0);
      // Zero threshold always fires.
      load_uniform(4'hF, 5'd0);
      run(16'h0000, 8'hFF, 0);
      // Threshold above the maximum count never fires.
      load_uniform(4'hF, 5'd17);
      run(16'hFFFF, 8'h00, 0);
      // Neuron n accumulates 2n; threshold 7 splits the layer.
      load_graded(16'hA5A5);
      for (int i = 0; i < 8; i++) tmem[i] = 5'd7;
      run(16'hA5A5, 8'hF0, 0);
      // Thresholds on the equality boundary: 2n for even n, 2n+1 for odd n.
      for (int i = 0; i < 8; i++) tmem[i] = 5'(2*i + (i % 2));
      run(16'hA5A5, 8'h55, 0);
      // Start re-pulsed mid-run must not restart.
      for (int i = 0; i < 8; i++) tmem[i] = 5'd7;
      run(16'hA5A5, 8'hF0, 10);

      // Reset in cycle 20 of a run clears outputs without waiting for a clock.
      load_uniform(4'hF, 5'd16);
      pulse_start(16'hFFFF);
      repeat (19) @(negedge Clk);
      #2 Reset = 1'b1;
      #1;
      check("midrun_reset_outs",
            {bus.WAddr, bus.WRdEn, bus.TAddr, bus.TRdEn, bus.Busy, bus.Done, bus.OutVec}, 32'd0);
      @(negedge Clk);
      Reset = 1'b0;
      begin
         int reads = 0;
         for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            if (bus.WRdEn || bus.TRdEn || bus.Busy) reads++;
         end
         check("idle_after_reset", reads, 0);
      end
      run(16'hFFFF, 8'hFF, 0);

`ifdef BNN_SCHED_ABORT_EN
      // Abort during cycle 12: neurons 0 and 1 are complete, neuron 2 is in flight.
      load_uniform(4'hF, 5'd16);
      pulse_start(16'hFFFF);
      repeat (11) @(negedge Clk);
      bus.Abort = 1'b1;
      @(negedge Clk);
      bus.Abort = 1'b0;
      check("abort_busy", {31'd0, bus.Busy}, 32'd0);
      check("abort_rden", {30'd0, bus.WRdEn, bus.TRdEn}, 32'd0);
      check("abort_outvec", {24'd0, bus.OutVec}, 32'h03);
      begin
         int dones = 0;
         for (int i = 0; i < 45; i++) begin
            @(negedge Clk);
            if (bus.Done) dones++;
         end
         check("abort_no_done", dones, 0);
      end
      run(16'hFFFF, 8'hFF, 0);
`endif

      repeat (3) @(negedge Clk);
      check("pending_expected", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end

endmodule

// File: doc/bnn_layer_sched.md
Name: bnn_layer_sched

Overview:
Sequencer that time-multiplexes one 4-input XNOR-popcount neuron slice across a full binary layer of NEURONS outputs, each with 4*IN_CHUNKS inputs. It walks the weight and threshold memories, accumulates per-chunk popcounts and thresholds each neuron, then presents the packed output vector. It sits between the CW305 register/control front-end (Start/Done) and the weight/threshold RAMs.

Parameters:
IN_CHUNKS, 4, number of 4-bit input chunks per neuron (inputs = 4*IN_CHUNKS)
NEURONS, 8, neurons in the layer (width of OutVec)
ACC_W, $clog2(4*IN_CHUNKS+1), accumulator and threshold width (default 5)
WA_W, $clog2(NEURONS*IN_CHUNKS), weight address width
TA_W, $clog2(NEURONS), threshold address width

Ports:
Clk  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-high; clears all state
Start  input  1  one-cycle request to run the layer; accepted only in IDLE
InVec  input  4*IN_CHUNKS  layer input bits; latched on Start acceptance
WAddr  output  WA_W  weight RAM address = neuron*IN_CHUNKS + chunk
WRdEn  output  1  weight RAM read enable
WData  input  4  weight chunk, valid the cycle after WRdEn (1-cycle sync read)
TAddr  output  TA_W  threshold RAM address = neuron index
TRdEn  output  1  threshold RAM read enable
TData  input  ACC_W  threshold, valid the cycle after TRdEn
Busy  output  1  high from Start acceptance until Done cycle inclusive
Done  output  1  one-cycle pulse, run complete
OutVec  output  NEURONS  bit n = result of neuron n

Behaviour:
- Reset values: WAddr=0, WRdEn=0, TAddr=0, TRdEn=0, Busy=0, Done=0, OutVec=0, state IDLE, acc=0. Reset mid-run aborts immediately; no further RAM reads.
- States: IDLE, RUN, FIN. IDLE->RUN on Start (latch InVec, clear OutVec, neuron n=0, chunk c=0, acc=0). FIN->IDLE after one cycle.
- RUN, per neuron n, cycles k=0..IN_CHUNKS: for k<IN_CHUNKS drive WRdEn=1, WAddr=n*IN_CHUNKS+k; at k=IN_CHUNKS-1 also TRdEn=1, TAddr=n. For k>=1, pc = count of ~(InVec[4(k-1)+i] ^ WData[i]), i=0..3 (0..4), acc += pc.
- At k=IN_CHUNKS: OutVec[n] = (acc_final >= TData) unsigned, acc_final including last chunk; acc cleared; n increments. Cycle k=IN_CHUNKS of neuron n does not overlap neuron n+1 reads.
- Per neuron IN_CHUNKS+1 cycles; Done asserted in FIN, NEURONS*(IN_CHUNKS+1)+1 cycles after the Start edge (default 41). Done rises with Busy still high; Busy falls next cycle.
- acc never overflows (max 4*IN_CHUNKS fits ACC_W). TData=0 -> bit always 1; TData>4*IN_CHUNKS -> bit always 0.
- Start while Busy: ignored, no restart. Start on the cycle FIN->IDLE: ignored; Start is sampled only in IDLE.
- OutVec bits update as neurons finish; stable and valid from Done until next accepted Start. InVec changes after acceptance have no effect.

Optional Feature:
BNN_SCHED_ABORT_EN: adds input Abort (1). When set, Abort high in RUN returns to IDLE next cycle: WRdEn/TRdEn=0, Busy=0, no Done pulse, OutVec holds partial results (unfinished bits 0). Abort in IDLE/FIN ignored. Without the macro the port is absent and runs always complete.

Test Plan:
- InVec=16'hFFFF, all weights 4'hF, all thresholds 16 -> OutVec=8'hFF, Done exactly 41 cycles after Start, Busy high 41 cycles.
- InVec=16'h0000, weights 4'hF, thresholds 1 -> every pc=0, OutVec=8'h00; thresholds 0 -> OutVec=8'hFF.
- InVec=16'hA5A5, neuron n weights = chunk-pattern giving acc=2n, thresholds 7 -> OutVec=8'hF0; WAddr sequence 0..31 with no gaps except compare cycles.
- Start re-pulsed at cycle 10 of a run -> no restart, Done still at cycle 41, results unchanged.
- Reset asserted at cycle 20 -> all outputs 0 asynchronously, state IDLE; new Start yields correct full run.
- With BNN_SCHED_ABORT_EN, Abort at cycle 12 -> Busy low next cycle, no Done, OutVec[1:0] valid, OutVec[7:2]=0.
